otter_pipe_hazard_ctrl: RTL and testbench
=========================================

// Module: otter_pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage OTTER (IF/ID/EX/MEM/WB). Consumes ID decode info (rd/rs, REG_WRITE,
//  MEM_READ_2) and EX branch resolution. Tracks in-flight writers in a shadow scoreboard. Drives PC/IF-ID enables,
//  bubble/flush controls, registered EX forwarding selects and stall/flush event counters.
// PARAMETERS
//  CNT_W   32  width of stall/flush event counters (wrap on overflow)
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RST          in   1   synchronous, active-high reset
//  id_vld       in   1   IF/ID holds a valid instruction
//  id_rs1       in   5   ID source reg 1
//  id_rs2       in   5   ID source reg 2
//  id_use_rs1   in   1   ID instruction reads rs1
//  id_use_rs2   in   1   ID instruction reads rs2
//  id_rd        in   5   ID destination reg
//  id_reg_write in   1   REG_WRITE from decoder
//  id_mem_read  in   1   MEM_READ_2 from decoder
//  ex_br_taken  in   1   EX instr is valid taken branch/JAL/JALR
//  dmem_stall   in   1   data memory not ready; whole pipe frozen
//  pc_write     out  1   PC register enable
//  ifid_write   out  1   IF/ID register enable
//  ifid_flush   out  1   IF/ID loads bubble
//  idex_flush   out  1   ID/EX loads bubble
//  fwd_a        out  2   EX operand A select: 0 RF, 1 EX/MEM result, 2 MEM/WB result
//  fwd_b        out  2   EX operand B select, same encoding
//  state        out  2   last-cycle action: RUN=0, STALL=1, FLUSH=2, FREEZE=3
//  cnt_stall    out  CNT_W  hazard-stall cycles since reset
//  cnt_flush    out  CNT_W  flush events since reset
// BEHAVIOUR
//  - Scoreboard sh_ex/sh_mem/sh_wb = {vld,rd,wr,ld}; advance ID->EX->MEM->WB each non-frozen cycle; stall/flush load
//    sh_ex.vld=0. dep(s,r) = s.vld & s.wr & s.rd!=0 & r==s.rd (per used rs). rd=x0 never creates a hazard.
//  - Priority per cycle: FREEZE (dmem_stall) > FLUSH (ex_br_taken) > STALL (hazard) > RUN.
//  - FREEZE: pc_write=ifid_write=0, no flush, scoreboard/fwd/state-other held; counters unchanged; state=FREEZE.
//  - FLUSH: pc_write=1 (loads target), ifid_write=1, ifid_flush=idex_flush=1; 2-cycle penalty; cnt_flush+=1 once
//    per event; a coincident hazard is dropped (ID instr killed).
//  - STALL: pc_write=ifid_write=0, idex_flush=1; cnt_stall+=1 per cycle; re-evaluated every cycle until clear.
//  - RUN: pc_write=ifid_write=1, flushes 0; fwd_a/fwd_b registered from ID compare: sh_ex match ->1, else sh_mem
//    match ->2, else 0 (youngest wins). Bubble/flush/stall cycles register fwd=0. id_vld=0 never stalls.
//  - Control outputs combinational from inputs+scoreboard; fwd/state/counters registered (visible next cycle).
//  - Reset: scoreboard invalid, fwd=0, state=RUN, counters 0; while RST=1 pc_write=ifid_write=0, both flushes=1.
//    RST mid-stall/flush aborts it; first post-reset cycle is RUN.
// CONFIGURATION
//  - OTTER_FWD_EN defined: stall only for load-use (dep on sh_ex with sh_ex.ld): exactly 1 bubble; fwd as above.
//  - OTTER_FWD_EN undefined: stall on any dep with sh_ex, sh_mem or sh_wb (RF not write-through); fwd_a=fwd_b=0.
//    Back-to-back ALU dependency costs 3 bubbles.
// STRUCTURE
//  - Package otter_pipe_pkg: opcode_t, fwd_sel_t (RF/EXMEM/MEMWB), ctrl_state_t, sb_entry_t struct.
//  - Sub-module otter_hazard_cmp: one scoreboard entry vs rs1/rs2 -> {dep_a, dep_b}; instantiated x3.
// TESTING
//  - add x5 then add x6,x5,x1 (FWD_EN) -> no stall, fwd_a=1 in consumer EX; 2nd-after consumer gets fwd_a=2.
//  - lw x5 then add x6,x5,x5 (FWD_EN) -> 1 STALL cycle, idex_flush=1, then fwd_a=fwd_b=1? no: =2; cnt_stall=1.
//  - add x5 then sub x7,x5,x0 (no FWD_EN) -> 3 stall cycles, cnt_stall=3, fwd stays 0.
//  - beq taken in EX while ID has load-use dep -> FLUSH: both flushes=1, no stall, cnt_flush=1, cnt_stall=0.
//  - dmem_stall=1 for 4 cycles during a load-use stall -> FREEZE x4, counters unchanged, stall resumes after.
//  - add x0,x1,x2 then add x3,x0,x0; and RST asserted mid-STALL -> no hazard; reset outputs, state=RUN after.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER pipeline hazard controller.
package otter_pipe_pkg;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } opcode_t;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};

   // Youngest in-flight producer wins.
   function automatic fwd_sel_t pick_fwd(input logic hit_ex, input logic hit_mem);
      if (hit_ex)
         return FWD_EXMEM;
      else if (hit_mem)
         return FWD_MEMWB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/otter_hazard_cmp.sv
// Compares one scoreboard entry against the ID source registers.
module otter_hazard_cmp
   import otter_pipe_pkg::*;
(
   input  sb_entry_t  ent,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       use_rs1,
   input  logic       use_rs2,
   output logic       dep_a,
   output logic       dep_b
);

   logic live;
   logic unused_ld;

   // x0 is hard-wired zero, so a write to it never produces a dependency.
   assign live      = ent.vld & ent.wr & (ent.rd != 5'd0);
   assign dep_a     = live & use_rs1 & (rs1 == ent.rd);
   assign dep_b     = live & use_rs2 & (rs2 == ent.rd);
   assign unused_ld = ent.ld;

endmodule

// File: rtl/otter_pipe_hazard_ctrl.sv
// OTTER 5-stage hazard/sequencing controller. Define OTTER_FWD_EN to enable
// EX forwarding (load-use stalls only); otherwise every RAW dependency stalls.
//
// state     | meaning
// ST_RUN    | pipe advances, ID issues into EX
// ST_STALL  | hazard: PC and IF/ID hold, bubble into EX
// ST_FLUSH  | taken branch in EX: IF/ID and ID/EX get bubbles
// ST_FREEZE | data memory busy: whole pipe holds
module otter_pipe_hazard_ctrl
   import otter_pipe_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             id_vld,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             ex_br_taken,
   input  logic             dmem_stall,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_flush
);

   sb_entry_t   sh_ex, sh_mem, sh_wb, id_ent;
   logic [1:0]  dep_ex, dep_mem, dep_wb;
   logic        hazard;
   ctrl_state_t state_q, act;
   fwd_sel_t    fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;
   logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q;

   assign id_ent = '{vld: id_vld, rd: id_rd, wr: id_reg_write, ld: id_mem_read};

   otter_hazard_cmp u_cmp_ex (
      .ent(sh_ex), .rs1(id_rs1), .rs2(id_rs2), .use_rs1(id_use_rs1), .use_rs2(id_use_rs2),
      .dep_a(dep_ex[1]), .dep_b(dep_ex[0])
   );
   otter_hazard_cmp u_cmp_mem (
      .ent(sh_mem), .rs1(id_rs1), .rs2(id_rs2), .use_rs1(id_use_rs1), .use_rs2(id_use_rs2),
      .dep_a(dep_mem[1]), .dep_b(dep_mem[0])
   );
   otter_hazard_cmp u_cmp_wb (
      .ent(sh_wb), .rs1(id_rs1), .rs2(id_rs2), .use_rs1(id_use_rs1), .use_rs2(id_use_rs2),
      .dep_a(dep_wb[1]), .dep_b(dep_wb[0])
   );

`ifdef OTTER_FWD_EN
   logic unused_wb;
   assign unused_wb = |dep_wb;
   // Only a load still in EX cannot be forwarded in time.
   assign hazard    = id_vld & sh_ex.ld & (|dep_ex);
`else
   // Register file is not write-through, so any producer up to WB blocks issue.
   assign hazard    = id_vld & (|{dep_ex, dep_mem, dep_wb});
`endif

   always_comb begin
      act        = ST_RUN;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (RST) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (dmem_stall) begin
         act        = ST_FREEZE;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (ex_br_taken) begin
         act        = ST_FLUSH;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (hazard) begin
         act        = ST_STALL;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      fwd_a_nxt = FWD_RF;
      fwd_b_nxt = FWD_RF;
`ifdef OTTER_FWD_EN
      if (act == ST_RUN && id_vld) begin
         fwd_a_nxt = pick_fwd(dep_ex[1], dep_mem[1]);
         fwd_b_nxt = pick_fwd(dep_ex[0], dep_mem[0]);
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state_q <= ST_RUN;
      else
         state_q <= act;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sh_ex       <= SB_EMPTY;
         sh_mem      <= SB_EMPTY;
         sh_wb       <= SB_EMPTY;
         fwd_a_q     <= FWD_RF;
         fwd_b_q     <= FWD_RF;
         cnt_stall_q <= '0;
         cnt_flush_q <= '0;
      end else if (act != ST_FREEZE) begin
         sh_wb   <= sh_mem;
         sh_mem  <= sh_ex;
         sh_ex   <= (act == ST_RUN) ? id_ent : SB_EMPTY;
         fwd_a_q <= fwd_a_nxt;
         fwd_b_q <= fwd_b_nxt;
         if (act == ST_STALL)
            cnt_stall_q <= cnt_stall_q + CNT_W'(1);
         if (act == ST_FLUSH)
            cnt_flush_q <= cnt_flush_q + CNT_W'(1);
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign state     = state_q;
   assign cnt_stall = cnt_stall_q;
   assign cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_otter_pipe_hazard_ctrl.sv
// Bench for otter_pipe_hazard_ctrl: directed program snippets then random traffic,
// checked against an instruction-level pipeline model (honours OTTER_FWD_EN).
module tb_otter_pipe_hazard_ctrl;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       wr;
      logic       ld;
   } ins_t;

   localparam int A_RUN = 0, A_STALL = 1, A_FLUSH = 2, A_FREEZE = 3, A_RST = 4;

   logic        CLK, RST;
   logic        id_vld, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        ex_br_taken, dmem_stall;
   logic        pc_write, ifid_write, ifid_flush, idex_flush;
   logic [1:0]  fwd_a, fwd_b, state;
   logic [31:0] cnt_stall, cnt_flush;

   otter_pipe_hazard_ctrl #(.CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_br_taken(ex_br_taken), .dmem_stall(dmem_stall),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
      .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          checks = 0;
   int          failures = 0;
   int          last_act = A_RUN;
   ins_t        cur;
   ins_t        prog[$];
   ins_t        stg[3];            // in-flight instructions: 0=EX, 1=MEM, 2=WB
   logic [1:0]  m_fa, m_fb, m_state;
   logic [31:0] m_stall, m_flush;
   logic [4:0]  pool[5] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd6};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic ins_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic wr, input logic ld);
      ins_t i;
      i.vld = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
      i.u1 = 1'b1; i.u2 = 1'b1; i.wr = wr; i.ld = ld;
      return i;
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      i.vld = ($urandom_range(0, 7) != 0);
      i.rd  = pool[$urandom_range(0, 4)];
      i.rs1 = pool[$urandom_range(0, 4)];
      i.rs2 = pool[$urandom_range(0, 4)];
      i.u1  = ($urandom_range(0, 3) != 0);
      i.u2  = ($urandom_range(0, 1) != 0);
      i.wr  = ($urandom_range(0, 3) != 0);
      i.ld  = i.wr && ($urandom_range(0, 2) == 0);
      return i;
   endfunction

   // Does in-flight instruction at stage s produce a register the consumer reads?
   function automatic bit produces(input int s, input logic [4:0] rs, input logic use_rs);
      return use_rs && stg[s].vld && stg[s].wr && (stg[s].rd != 5'd0) && (stg[s].rd == rs);
   endfunction

   function automatic logic [1:0] fwd_of(input logic [4:0] rs, input logic use_rs);
`ifdef OTTER_FWD_EN
      for (int s = 0; s < 2; s++)
         if (produces(s, rs, use_rs)) return 2'(s + 1);
`endif
      return 2'd0;
   endfunction

   task automatic cycle(input bit br, input bit dm, input bit rs);
      int         act;
      bit         haz;
      logic [1:0] fa, fb;
      if (!cur.vld && prog.size() > 0 && !rs) cur = prog.pop_front();
      RST = rs; ex_br_taken = br; dmem_stall = dm;
      id_vld = cur.vld; id_rd = cur.rd; id_rs1 = cur.rs1; id_rs2 = cur.rs2;
      id_use_rs1 = cur.u1; id_use_rs2 = cur.u2; id_reg_write = cur.wr; id_mem_read = cur.ld;
      haz = 1'b0;
      if (cur.vld) begin
`ifdef OTTER_FWD_EN
         haz = stg[0].ld && (produces(0, cur.rs1, cur.u1) || produces(0, cur.rs2, cur.u2));
`else
         for (int s = 0; s < 3; s++)
            if (produces(s, cur.rs1, cur.u1) || produces(s, cur.rs2, cur.u2)) haz = 1'b1;
`endif
      end
      if (rs)       act = A_RST;
      else if (dm)  act = A_FREEZE;
      else if (br)  act = A_FLUSH;
      else if (haz) act = A_STALL;
      else          act = A_RUN;
      fa = (act == A_RUN && cur.vld) ? fwd_of(cur.rs1, cur.u1) : 2'd0;
      fb = (act == A_RUN && cur.vld) ? fwd_of(cur.rs2, cur.u2) : 2'd0;

      @(negedge CLK);
      chk("pc_write",   32'(pc_write),   32'(act == A_RUN || act == A_FLUSH));
      chk("ifid_write", 32'(ifid_write), 32'(act == A_RUN || act == A_FLUSH));
      chk("ifid_flush", 32'(ifid_flush), 32'(act == A_RST || act == A_FLUSH));
      chk("idex_flush", 32'(idex_flush), 32'(act == A_RST || act == A_FLUSH || act == A_STALL));

      @(posedge CLK); #1;
      if (act == A_RST) begin
         for (int s = 0; s < 3; s++) stg[s] = '0;
         m_fa = 2'd0; m_fb = 2'd0; m_state = 2'd0; m_stall = 0; m_flush = 0;
         prog.delete();
         cur = '0;
      end else if (act == A_FREEZE) begin
         m_state = 2'd3;
      end else begin
         stg[2] = stg[1];
         stg[1] = stg[0];
         stg[0] = (act == A_RUN) ? cur : '0;
         m_fa = fa; m_fb = fb;
         m_state = 2'(act);
         if (act == A_STALL) m_stall++;
         if (act == A_FLUSH) m_flush++;
         if (act == A_RUN || act == A_FLUSH) cur = '0;
      end
      last_act = act;
      chk("fwd_a",     32'(fwd_a), 32'(m_fa));
      chk("fwd_b",     32'(fwd_b), 32'(m_fb));
      chk("state",     32'(state), 32'(m_state));
      chk("cnt_stall", cnt_stall,  m_stall);
      chk("cnt_flush", cnt_flush,  m_flush);
   endtask

   task automatic drain();
      int n = 0;
      while ((cur.vld || prog.size() > 0) && n < 40) begin
         cycle(1'b0, 1'b0, 1'b0);
         n++;
      end
      chk("drain_bound", 32'(n < 40), 32'd1);
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      cur = '0;
      for (int s = 0; s < 3; s++) stg[s] = '0;
      m_fa = 0; m_fb = 0; m_state = 0; m_stall = 0; m_flush = 0;
      RST = 1'b1; ex_br_taken = 0; dmem_stall = 0; id_vld = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_mem_read = 0;

      // reset, with a freeze request that reset must override
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      chk("reset_cnt_stall", cnt_stall, 32'd0);
      chk("reset_state", 32'(state), 32'd0);

      // add x5; add x6,x5,x1; add x8,x5,x2
      prog.push_back(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b0));
      prog.push_back(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b0));
      prog.push_back(mk(5'd8, 5'd5, 5'd2, 1'b1, 1'b0));
      drain();

      // lw x5; add x6,x5,x5
      prog.push_back(mk(5'd5, 5'd1, 5'd0, 1'b1, 1'b1));
      prog.push_back(mk(5'd6, 5'd5, 5'd5, 1'b1, 1'b0));
      drain();

      // add x5; sub x7,x5,x0
      prog.push_back(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b0));
      prog.push_back(mk(5'd7, 5'd5, 5'd0, 1'b1, 1'b0));
      drain();

      // taken branch in EX while ID holds a load-use consumer
      prog.push_back(mk(5'd5, 5'd1, 5'd0, 1'b1, 1'b1));
      prog.push_back(mk(5'd6, 5'd5, 5'd5, 1'b1, 1'b0));
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      drain();

      // dmem_stall for 4 cycles over a load-use stall
      prog.push_back(mk(5'd5, 5'd1, 5'd0, 1'b1, 1'b1));
      prog.push_back(mk(5'd6, 5'd5, 5'd5, 1'b1, 1'b0));
      cycle(1'b0, 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 1'b1, 1'b0);
      drain();

      // writes to x0 never create a hazard
      prog.push_back(mk(5'd0, 5'd1, 5'd2, 1'b1, 1'b1));
      prog.push_back(mk(5'd3, 5'd0, 5'd0, 1'b1, 1'b0));
      drain();

      // reset in the middle of a stall
      prog.push_back(mk(5'd5, 5'd1, 5'd0, 1'b1, 1'b1));
      prog.push_back(mk(5'd6, 5'd5, 5'd5, 1'b1, 1'b0));
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);

      // random traffic
      for (int n = 0; n < 500; n++) begin
         bit br, dm, rs;
         if (prog.size() < 2) prog.push_back(rand_ins());
         dm = ($urandom_range(0, 9) == 0);
         br = (last_act != A_FLUSH) && ($urandom_range(0, 11) == 0);
         rs = ($urandom_range(0, 149) == 0);
         cycle(br, dm, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
